// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline-boundary register.
//               - pipe_state_e : occupancy of the two-slot stage
//               - *_DEF        : default payload / control / counter widths
//               - c_nop_bit    : replicated to form the all-zero NOP control
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int CTRL_W_DEF = 11;
   localparam int CNT_W_DEF  = 16;

   // Every control bit of a NOP is zero, whatever the control width.
   localparam logic c_nop_bit = 1'b0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One payload+valid holding register of the stage.
//               Clear has priority over load.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset (clears the slot)
//               i_load   - capture i_valid / i_data
//               i_clear  - empty the slot (valid=0, data=0)
//               i_valid  - valid bit to capture
//               i_data   - payload to capture
//               o_valid  - held valid bit
//               o_data   - held payload
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= i_valid;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Pipeline-boundary register with valid/ready handshake, a
//               2-entry skid buffer (so o_in_ready never depends on
//               i_out_ready combinationally), hazard bubble insertion,
//               synchronous flush and a saturating bubble counter.
// Ports       : clk          - clock
//               rst_n        - asynchronous active-low reset
//               i_flush      - squash all held entries (highest priority)
//               i_bubble     - insert a NOP entry and hold upstream
//               i_in_valid   - upstream entry present
//               o_in_ready   - stage accepts the upstream entry this cycle
//               i_in_data    - upstream payload
//               i_in_ctrl    - upstream control field
//               o_out_valid  - entry presented downstream
//               i_out_ready  - downstream accepts (low = stall)
//               o_out_data   - presented payload
//               o_out_ctrl   - presented control field
//               o_bubble_cnt - bubbles inserted since reset, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_flush,
   input  logic              i_bubble,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic [CTRL_W-1:0] i_in_ctrl,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [CTRL_W-1:0] o_out_ctrl,
   output logic [CNT_W-1:0]  o_bubble_cnt
);

   // Slot payload is {ctrl, data}.
   localparam int c_pay_w = DATA_W + CTRL_W;

   pipe_state_e          r_state;
   pipe_state_e          w_state_nxt;
   logic [CNT_W-1:0]     r_bubble_cnt;

   logic                 w_push;
   logic                 w_bpush;
   logic                 w_ld;
   logic                 w_pop;
   logic [c_pay_w-1:0]   w_ld_payload;

   logic                 w_main_load;
   logic                 w_main_clear;
   logic                 w_main_from_skid;
   logic                 w_main_valid_in;
   logic [c_pay_w-1:0]   w_main_data_in;
   logic                 w_main_valid;
   logic [c_pay_w-1:0]   w_main_data;

   logic                 w_skid_load;
   logic                 w_skid_clear;
   logic                 w_skid_valid;
   logic [c_pay_w-1:0]   w_skid_data;

   // ------------------------------------------------------------------
   // Handshake terms. in_ready depends only on local state and hazard
   // inputs, never on i_out_ready.
   // ------------------------------------------------------------------
   assign o_in_ready = (r_state != SKID) && !i_flush && !i_bubble;
   assign w_push     = i_in_valid && o_in_ready;
   assign w_bpush    = i_bubble && (r_state != SKID) && !i_flush;
   assign w_ld       = w_push || w_bpush;
   assign w_pop      = o_out_valid && i_out_ready;

   // A bubble is a valid entry whose control and data are all zero.
   assign w_ld_payload = w_bpush ? {{CTRL_W{c_nop_bit}}, {DATA_W{1'b0}}}
                                 : {i_in_ctrl, i_in_data};

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state and slot control
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_main_load      = 1'b0;
      w_main_clear     = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
      w_skid_clear     = 1'b0;

      if (i_flush) begin
         w_state_nxt  = EMPTY;
         w_main_clear = 1'b1;
         w_skid_clear = 1'b1;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_ld) begin
                  w_main_load = 1'b1;
                  w_state_nxt = FULL;
               end
            end
            FULL: begin
               if (w_ld && w_pop) begin
                  w_main_load = 1'b1;
               end else if (w_ld) begin
                  // Downstream stalled: park the new entry behind main.
                  w_skid_load = 1'b1;
                  w_state_nxt = SKID;
               end else if (w_pop) begin
                  w_main_clear = 1'b1;
                  w_state_nxt  = EMPTY;
               end
            end
            SKID: begin
               if (w_pop) begin
                  w_main_load      = 1'b1;
                  w_main_from_skid = 1'b1;
                  w_skid_clear     = 1'b1;
                  w_state_nxt      = FULL;
               end
            end
            default: begin
               w_state_nxt  = EMPTY;
               w_main_clear = 1'b1;
               w_skid_clear = 1'b1;
            end
         endcase
      end
   end

   assign w_main_valid_in = w_main_from_skid ? w_skid_valid : 1'b1;
   assign w_main_data_in  = w_main_from_skid ? w_skid_data  : w_ld_payload;

   pipe_slot #(
      .W (c_pay_w)
   ) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_main_load),
      .i_clear (w_main_clear),
      .i_valid (w_main_valid_in),
      .i_data  (w_main_data_in),
      .o_valid (w_main_valid),
      .o_data  (w_main_data)
   );

   pipe_slot #(
      .W (c_pay_w)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_valid (1'b1),
      .i_data  (w_ld_payload),
      .o_valid (w_skid_valid),
      .o_data  (w_skid_data)
   );

   // The main slot's valid bit is set exactly when the stage leaves EMPTY
   // and cleared exactly when it returns there, so it doubles as out_valid.
   assign o_out_valid = w_main_valid;
   assign o_out_data  = w_main_data[DATA_W-1:0];
   assign o_out_ctrl  = w_main_data[c_pay_w-1:DATA_W];

   // ------------------------------------------------------------------
   // Bubble statistics: saturating, untouched by flush.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bubble_cnt <= '0;
      end else if (w_bpush && !(&r_bubble_cnt)) begin
         r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_bubble_cnt = r_bubble_cnt;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. A queue model of the
//               stage (capacity two, FIFO order) predicts every output on
//               every cycle; directed scenarios add literal expectations.
//               A second instance with a 2-bit counter shares all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

   localparam int DW = 64;
   localparam int CW = 11;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          bubble;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_ready;

   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [15:0]   bubble_cnt;

   logic          s_in_ready;
   logic          s_out_valid;
   logic [DW-1:0] s_out_data;
   logic [CW-1:0] s_out_ctrl;
   logic [1:0]    s_bubble_cnt;

   int n_vec;
   int n_err;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (flush),
      .i_bubble     (bubble),
      .i_in_valid   (in_valid),
      .o_in_ready   (in_ready),
      .i_in_data    (in_data),
      .i_in_ctrl    (in_ctrl),
      .o_out_valid  (out_valid),
      .i_out_ready  (out_ready),
      .o_out_data   (out_data),
      .o_out_ctrl   (out_ctrl),
      .o_bubble_cnt (bubble_cnt)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2)) dut_small (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (flush),
      .i_bubble     (bubble),
      .i_in_valid   (in_valid),
      .o_in_ready   (s_in_ready),
      .i_in_data    (in_data),
      .i_in_ctrl    (in_ctrl),
      .o_out_valid  (s_out_valid),
      .i_out_ready  (out_ready),
      .o_out_data   (s_out_data),
      .o_out_ctrl   (s_out_ctrl),
      .o_bubble_cnt (s_bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: an ordered list of held entries, at most two.
   // ------------------------------------------------------------------
   logic [CW+DW-1:0] q[$];
   int               m_cnt;
   int               m_sz;
   logic             m_rdy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_cnt = 0;
      end else begin
         m_sz = q.size();
         if (flush) begin
            q.delete();
         end else begin
            m_rdy = (m_sz < 2) && !bubble;
            if (m_sz > 0 && out_ready) void'(q.pop_front());
            if (in_valid && m_rdy) begin
               q.push_back({in_ctrl, in_data});
            end else if (bubble && m_sz < 2) begin
               q.push_back('0);
               if (m_cnt < 65535) m_cnt++;
            end
         end
      end
   end

   logic          e_rdy;
   logic          e_vld;
   logic [DW-1:0] e_data;
   logic [CW-1:0] e_ctrl;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         e_rdy  = (q.size() < 2) && !flush && !bubble;
         e_vld  = (q.size() != 0);
         e_data = e_vld ? q[0][DW-1:0] : '0;
         e_ctrl = e_vld ? q[0][CW+DW-1:DW] : '0;
         check("in_ready",       64'(in_ready),     64'(e_rdy));
         check("out_valid",      64'(out_valid),    64'(e_vld));
         check("out_data",       out_data,          e_data);
         check("out_ctrl",       64'(out_ctrl),     64'(e_ctrl));
         check("bubble_cnt",     64'(bubble_cnt),   64'(m_cnt));
         check("s_in_ready",     64'(s_in_ready),   64'(e_rdy));
         check("s_out_valid",    64'(s_out_valid),  64'(e_vld));
         check("s_out_data",     s_out_data,        e_data);
         check("s_out_ctrl",     64'(s_out_ctrl),   64'(e_ctrl));
         check("s_bubble_cnt",   64'(s_bubble_cnt), 64'((m_cnt > 3) ? 3 : m_cnt));
      end
   end

   // Advance one cycle: drive inputs just after the rising edge, return at
   // the following falling edge where outputs are stable.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic bub, input logic fl);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      bubble    = bub;
      flush     = fl;
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, '0, '0, ordy, 1'b0, 1'b0);
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      bubble    = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst out_valid",  64'(out_valid),  64'd0);
      check("rst out_data",   out_data,        64'd0);
      check("rst out_ctrl",   64'(out_ctrl),   64'd0);
      check("rst bubble_cnt", 64'(bubble_cnt), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1'b1);
      check("post-rst in_ready", 64'(in_ready), 64'd1);

      // Four back-to-back pushes, downstream always ready
      step(1'b1, 64'h11, 11'h001, 1'b1, 1'b0, 1'b0);
      check("b2b first cycle out_valid", 64'(out_valid), 64'd0);
      step(1'b1, 64'h22, 11'h002, 1'b1, 1'b0, 1'b0);
      check("b2b out0", out_data, 64'h11);
      check("b2b valid", 64'(out_valid), 64'd1);
      step(1'b1, 64'h33, 11'h003, 1'b1, 1'b0, 1'b0);
      check("b2b out1", out_data, 64'h22);
      step(1'b1, 64'h44, 11'h004, 1'b1, 1'b0, 1'b0);
      check("b2b out2", out_data, 64'h33);
      check("b2b in_ready", 64'(in_ready), 64'd1);
      idle(1'b1);
      check("b2b out3", out_data, 64'h44);
      idle(1'b1);
      check("b2b drained", 64'(out_valid), 64'd0);

      // Downstream stall fills the skid slot
      step(1'b1, 64'hA1, 11'h0A1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'hA2, 11'h0A2, 1'b0, 1'b0, 1'b0);
      check("stall head", out_data, 64'hA1);
      idle(1'b0);
      check("skid in_ready", 64'(in_ready), 64'd0);
      check("skid head", out_data, 64'hA1);
      idle(1'b0);
      check("skid hold", out_data, 64'hA1);
      idle(1'b1);
      check("release 1", out_data, 64'hA1);
      idle(1'b1);
      check("release 2", out_data, 64'hA2);
      idle(1'b1);
      check("release drained", 64'(out_valid), 64'd0);

      // Bubble while upstream offers an entry
      step(1'b1, 64'hB1, 11'h7FF, 1'b1, 1'b1, 1'b0);
      check("bubble in_ready", 64'(in_ready), 64'd0);
      step(1'b1, 64'hB1, 11'h7FF, 1'b1, 1'b0, 1'b0);
      check("bubble out_valid", 64'(out_valid), 64'd1);
      check("bubble out_ctrl", 64'(out_ctrl), 64'd0);
      check("bubble out_data", out_data, 64'd0);
      check("bubble count", 64'(bubble_cnt), 64'd1);
      idle(1'b1);
      check("held entry ctrl", 64'(out_ctrl), 64'h7FF);
      check("held entry data", out_data, 64'hB1);
      idle(1'b1);

      // Flush from SKID
      step(1'b1, 64'hC1, 11'h0C1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'hC2, 11'h0C2, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      check("pre-flush in_ready", 64'(in_ready), 64'd0);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      check("flush out_valid", 64'(out_valid), 64'd0);
      check("flush out_ctrl", 64'(out_ctrl), 64'd0);
      check("flush in_ready", 64'(in_ready), 64'd1);
      check("flush count", 64'(bubble_cnt), 64'd1);

      // Bubble and flush together from FULL
      step(1'b1, 64'hD1, 11'h0D1, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      idle(1'b1);
      check("bub+flush empty", 64'(out_valid), 64'd0);
      check("bub+flush count", 64'(bubble_cnt), 64'd1);

      // Five bubbles: wide counter 6, narrow counter pinned at 3
      for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      check("wide count", 64'(bubble_cnt), 64'd6);
      check("narrow sat", 64'(s_bubble_cnt), 64'd3);
      idle(1'b1);

      // Asynchronous reset while in SKID
      step(1'b1, 64'hE1, 11'h0E1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'hE2, 11'h0E2, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      check("pre-reset valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async rst out_valid", 64'(out_valid), 64'd0);
      check("async rst out_data", out_data, 64'd0);
      check("async rst out_ctrl", 64'(out_ctrl), 64'd0);
      check("async rst count", 64'(bubble_cnt), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1'b1, 64'hF1, 11'h0F1, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      check("after reset data", out_data, 64'hF1);
      idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_pipe_stage_reg
`default_nettype wire
